// File: rtl/mat_scalar_seq.sv
// Sequenced scalar-by-matrix multiplier: one 9x8 product per clock over 25 latched
// elements, result accumulated in a 225-bit register with a done pulse at the end.
module mat_scalar_seq (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [224:0] i_matriz_A,
  input  logic [7:0]   i_const,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_result_valid,
  output logic         o_ovf_any,
  output logic [224:0] o_resultado
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       r_state, w_next;
  logic [4:0]   r_idx;
  logic [224:0] r_mat;
  logic [7:0]   r_k;
  logic [224:0] r_res;
  logic         r_valid;
  logic         r_ovf_any;

  logic [7:0]   w_base;
  logic [8:0]   w_elem;
  logic [16:0]  w_prod;
  logic         w_ovf;
  logic         w_last;
  logic         w_accept;
  logic         w_write;

  assign w_base = {3'b000, r_idx} * 8'd9;
  assign w_elem = r_mat[w_base +: 9];
  assign w_prod = {8'b0, w_elem} * {9'b0, r_k};
  // Anything above the low byte is lost in the 8-bit payload, so it flags overflow.
  assign w_ovf  = |w_prod[16:8];
  assign w_last = (r_idx == 5'd24);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_write  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_next = S_IDLE;
        end else begin
          w_write = 1'b1;
          if (w_last) w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx     <= '0;
      r_mat     <= '0;
      r_k       <= '0;
      r_res     <= '0;
      r_valid   <= 1'b0;
      r_ovf_any <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mat     <= i_matriz_A;
        r_k       <= i_const;
        r_idx     <= '0;
        r_res     <= '0;
        r_valid   <= 1'b0;
        r_ovf_any <= 1'b0;
      end
      if (w_write) begin
        r_res[w_base +: 9] <= {w_ovf, w_prod[7:0]};
        r_ovf_any          <= r_ovf_any | w_ovf;
        r_idx              <= w_last ? 5'd0 : r_idx + 5'd1;
        if (w_last) r_valid <= 1'b1;
      end
    end
  end

  assign o_busy         = (r_state == S_RUN);
  assign o_done         = (r_state == S_DONE);
  assign o_result_valid = r_valid;
  assign o_ovf_any      = r_ovf_any;
  assign o_resultado    = r_res;

endmodule

// File: tb/tb_mat_scalar_seq.sv
// Randomized scoreboard bench for mat_scalar_seq: the driver pushes expected results
// from an arithmetic model on each accepted start; a monitor checks every done pulse.
module tb_mat_scalar_seq;

  logic         clk = 1'b0;
  logic         rst_n, start, abort;
  logic [224:0] mat;
  logic [7:0]   k;
  logic         busy, done, rv, ovf;
  logic [224:0] res;

  always #5 clk = ~clk;

  mat_scalar_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_matriz_A(mat), .i_const(k),
    .o_busy(busy), .o_done(done), .o_result_valid(rv), .o_ovf_any(ovf),
    .o_resultado(res)
  );

  typedef struct {
    logic [224:0] res;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  // Reference: every element times the scalar, overflow if product exceeds a byte.
  function automatic exp_t model(input logic [224:0] m, input logic [7:0] c, input int acc);
    exp_t e;
    int   p;
    e.res = '0;
    e.ovf = 1'b0;
    e.acc = acc;
    for (int i = 0; i < 25; i++) begin
      p = int'(m[i*9 +: 9]) * int'(c);
      e.res[i*9 +: 9] = {(p > 255), 8'(p % 256)};
      if (p > 255) e.ovf = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [224:0] rand_mat();
    logic [224:0] m;
    for (int i = 0; i < 25; i++) m[i*9 +: 9] = 9'($urandom);
    return m;
  endfunction

  function automatic logic [224:0] fill_mat(input logic [8:0] v);
    logic [224:0] m;
    for (int i = 0; i < 25; i++) m[i*9 +: 9] = v;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [224:0] a, input logic [224:0] e);
    ncmp++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      chk("done_pulse_width", {224'b0, prev_done}, 225'd0);
      if (q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
      end else begin
        me = q.pop_front();
        chk("resultado", res, me.res);
        chk("ovf_any", {224'b0, ovf}, {224'b0, me.ovf});
        chk("result_valid", {224'b0, rv}, 225'd1);
        chk("busy_at_done", {224'b0, busy}, 225'd0);
        chk("latency", 225'(cyc - me.acc), 225'd25);
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [224:0] m, input logic [7:0] c, input bit expect_done);
    mat   = m;
    k     = c;
    start = 1'b1;
    for (int n = 0; n < 40 && !busy; n++) tick();
    start = 1'b0;
    if (!busy) begin
      ncmp++;
      nfail++;
      $display("FAIL accept_timeout: got busy=0 want busy=1 within 40 cycles");
    end else if (expect_done) begin
      q.push_back(model(m, c, cyc));
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 40 && !done; n++) tick();
    if (!done) begin
      ncmp++;
      nfail++;
      $display("FAIL done_timeout: got done=0 want done=1 within 40 cycles");
    end
  endtask

  task automatic run_op(input logic [224:0] m, input logic [7:0] c);
    issue(m, c, 1'b1);
    wait_done();
  endtask

  initial begin
    logic [224:0] m1, m2, part;
    logic [7:0]   k2;
    exp_t         ea;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mat = '0; k = '0;
    repeat (3) tick();
    chk("rst_busy", {224'b0, busy}, 225'd0);
    chk("rst_done", {224'b0, done}, 225'd0);
    chk("rst_valid", {224'b0, rv}, 225'd0);
    chk("rst_ovf", {224'b0, ovf}, 225'd0);
    chk("rst_res", res, 225'd0);
    rst_n = 1'b1;
    tick();

    run_op(fill_mat(9'd10), 8'd3);

    m1 = fill_mat(9'd1);
    m1[0 +: 9]   = 9'd255;
    m1[216 +: 9] = 9'h1FF;
    run_op(m1, 8'd2);
    run_op(m1, 8'd255);

    run_op(rand_mat(), 8'd0);
    run_op(fill_mat(9'h0FF), 8'd1);

    // Starts during RUN with changed operands must not disturb the operation.
    m1 = rand_mat();
    m2 = rand_mat();
    k2 = 8'($urandom);
    issue(m1, 8'($urandom), 1'b1);
    mat = m2;
    k   = k2;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_ignored_start", {224'b0, busy}, 225'd1);
    repeat (19) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("done_at_25", {224'b0, done}, 225'd1);
    wait_done();
    run_op(m2, k2);

    // Abort sampled on the 10th RUN edge: elements 0..8 written, the rest untouched.
    m1 = rand_mat();
    k2 = 8'($urandom_range(2, 255));
    ea = model(m1, k2, 0);
    issue(m1, k2, 1'b0);
    repeat (9) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", {224'b0, busy}, 225'd0);
    chk("abort_done", {224'b0, done}, 225'd0);
    chk("abort_valid", {224'b0, rv}, 225'd0);
    part = ea.res;
    part[224:81] = '0;
    chk("abort_partial", res, part);
    repeat (5) tick();
    run_op(rand_mat(), 8'($urandom));

    // Reset on the 12th RUN edge, with start held through reset.
    issue(rand_mat(), 8'($urandom), 1'b0);
    repeat (11) tick();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    chk("midrst_busy", {224'b0, busy}, 225'd0);
    chk("midrst_done", {224'b0, done}, 225'd0);
    chk("midrst_valid", {224'b0, rv}, 225'd0);
    chk("midrst_ovf", {224'b0, ovf}, 225'd0);
    chk("midrst_res", res, 225'd0);
    repeat (3) tick();
    chk("start_in_reset", {224'b0, busy}, 225'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    run_op(rand_mat(), 8'($urandom));

    for (int t = 0; t < 5; t++) run_op(rand_mat(), 8'($urandom));
    run_op(fill_mat(9'h1FF), 8'd255);

    repeat (4) tick();
    chk("queue_drained", 225'(q.size()), 225'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
